// File: rtl/dram_bridge_pkg.sv
// Shared types and constants for the single-outstanding DRAM command bridge.
package dram_bridge_pkg;

   // DRAM geometry: one 64-bit word per address, 8192 words.
   localparam int DRAM_DEPTH  = 8192;
   localparam int DEPTH_W_DEF = $clog2(DRAM_DEPTH);
   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 64;
   localparam int RESP_W      = 2;

   localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

   // Bridge sequencing: reads walk AR -> R, writes walk AW -> W -> B,
   // both finish with a one-cycle DONE that carries the completion pulse.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_AW   = 3'd3,
      S_W    = 3'd4,
      S_B    = 3'd5,
      S_DONE = 3'd6
   } bridge_state_e;

   // Any response other than OKAY is reported as an error.
   function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/dram_bridge_if.sv
// Five-channel AXI-style link between the bridge (master) and the pseudo DRAM (slave).
//
// Handshake rule for every channel: a transfer happens on the rising clock edge
// where both VALID and READY are 1. Once the source raises VALID it keeps VALID
// and its payload (ADDR/DATA) constant until that edge; payload is 0 whenever
// VALID is 0. READY seen while VALID is 0 has no effect.
interface dram_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) ();

   // Read address channel
   logic              AR_VALID;
   logic [ADDR_W-1:0] AR_ADDR;
   logic              AR_READY;
   // Read data channel
   logic              R_VALID;
   logic [DATA_W-1:0] R_DATA;
   logic [1:0]        R_RESP;
   logic              R_READY;
   // Write address channel
   logic              AW_VALID;
   logic [ADDR_W-1:0] AW_ADDR;
   logic              AW_READY;
   // Write data channel
   logic              W_VALID;
   logic [DATA_W-1:0] W_DATA;
   logic              W_READY;
   // Write response channel
   logic              B_VALID;
   logic [1:0]        B_RESP;
   logic              B_READY;

   modport master (
      output AR_VALID, AR_ADDR, R_READY,
      output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
      input  AR_READY, R_VALID, R_DATA, R_RESP,
      input  AW_READY, W_READY, B_VALID, B_RESP
   );

   modport slave (
      input  AR_VALID, AR_ADDR, R_READY,
      input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
      output AR_READY, R_VALID, R_DATA, R_RESP,
      output AW_READY, W_READY, B_VALID, B_RESP
   );

endinterface

// File: rtl/dram_bridge.sv
// Single-outstanding command bridge: takes one read or write from the core side,
// walks the DRAM channels strictly in order and returns one completion pulse.
// Every output is a flop, so payloads are naturally stable between handshakes.
module dram_bridge
   import dram_bridge_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH_W = DEPTH_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   // Core-side command port
   input  logic                in_valid,
   input  logic                direction,
   input  logic [DEPTH_W-1:0]  addr_dram,
   input  logic [DATA_W-1:0]   data_in,
   output logic                out_valid,
   output logic [DATA_W-1:0]   data_out,
   output logic                resp_err,
   // Current FSM state, for observation only
   output bridge_state_e       state_o,
   // DRAM-side channels
   dram_bridge_if.master       dram
);

   bridge_state_e     state_q;

   // Write data held from command acceptance until the W channel opens.
   logic [DATA_W-1:0] wdata_q;

   // Registered channel outputs
   logic              ar_valid_q;
   logic [ADDR_W-1:0] ar_addr_q;
   logic              r_ready_q;
   logic              aw_valid_q;
   logic [ADDR_W-1:0] aw_addr_q;
   logic              w_valid_q;
   logic [DATA_W-1:0] w_data_q;
   logic              b_ready_q;

   // Registered completion outputs
   logic              out_valid_q;
   logic [DATA_W-1:0] data_out_q;
   logic              resp_err_q;

   // Command sequencer: each handshake edge closes one channel and opens the
   // next on the same edge, so no bubble cycles appear between channels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wdata_q     <= '0;
         ar_valid_q  <= 1'b0;
         ar_addr_q   <= '0;
         r_ready_q   <= 1'b0;
         aw_valid_q  <= 1'b0;
         aw_addr_q   <= '0;
         w_valid_q   <= 1'b0;
         w_data_q    <= '0;
         b_ready_q   <= 1'b0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  wdata_q <= data_in;
                  if (!direction) begin
                     ar_valid_q <= 1'b1;
                     ar_addr_q  <= ADDR_W'(addr_dram);
                     state_q    <= S_AR;
                  end else begin
                     aw_valid_q <= 1'b1;
                     aw_addr_q  <= ADDR_W'(addr_dram);
                     state_q    <= S_AW;
                  end
               end
            end

            S_AR: begin
               if (dram.AR_READY) begin
                  ar_valid_q <= 1'b0;
                  ar_addr_q  <= '0;
                  r_ready_q  <= 1'b1;
                  state_q    <= S_R;
               end
            end

            // Read data and response are captured straight into the
            // completion registers, which are presented during DONE.
            S_R: begin
               if (dram.R_VALID) begin
                  r_ready_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  data_out_q  <= dram.R_DATA;
                  resp_err_q  <= resp_is_err(dram.R_RESP);
                  state_q     <= S_DONE;
               end
            end

            S_AW: begin
               if (dram.AW_READY) begin
                  aw_valid_q <= 1'b0;
                  aw_addr_q  <= '0;
                  w_valid_q  <= 1'b1;
                  w_data_q   <= wdata_q;
                  state_q    <= S_W;
               end
            end

            S_W: begin
               if (dram.W_READY) begin
                  w_valid_q <= 1'b0;
                  w_data_q  <= '0;
                  b_ready_q <= 1'b1;
                  state_q   <= S_B;
               end
            end

            // Writes complete with zero data; only the response is reported.
            S_B: begin
               if (dram.B_VALID) begin
                  b_ready_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  data_out_q  <= '0;
                  resp_err_q  <= resp_is_err(dram.B_RESP);
                  state_q     <= S_DONE;
               end
            end

            // Completion is visible for exactly this one cycle; data_out and
            // resp_err return to 0 together with out_valid.
            S_DONE: begin
               out_valid_q <= 1'b0;
               data_out_q  <= '0;
               resp_err_q  <= 1'b0;
               state_q     <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Drive the DRAM channels and core-side outputs from their flops.
   assign dram.AR_VALID = ar_valid_q;
   assign dram.AR_ADDR  = ar_addr_q;
   assign dram.R_READY  = r_ready_q;
   assign dram.AW_VALID = aw_valid_q;
   assign dram.AW_ADDR  = aw_addr_q;
   assign dram.W_VALID  = w_valid_q;
   assign dram.W_DATA   = w_data_q;
   assign dram.B_READY  = b_ready_q;

   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign resp_err  = resp_err_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_dram_bridge.sv
// Directed bench for dram_bridge with a behavioural DRAM slave and a protocol monitor.
module tb_dram_bridge;
   import dram_bridge_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 64;
   localparam int DEPTH_W = 13;
   localparam int BUDGET  = 400;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic               in_valid;
   logic               direction;
   logic [DEPTH_W-1:0] addr_dram;
   logic [DATA_W-1:0]  data_in;
   logic               out_valid;
   logic [DATA_W-1:0]  data_out;
   logic               resp_err;
   bridge_state_e      state_o;

   dram_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dram_if ();

   dram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .direction (direction),
      .addr_dram (addr_dram),
      .data_in   (data_in),
      .out_valid (out_valid),
      .data_out  (data_out),
      .resp_err  (resp_err),
      .state_o   (state_o),
      .dram      (dram_if)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- DRAM slave model ----------------
   logic [DATA_W-1:0] mem [0:8191];
   int unsigned stall_min = 0;
   int unsigned stall_max = 0;
   logic [1:0]  force_resp = 2'b00;
   logic [ADDR_W-1:0] aw_addr_seen;
   logic [DATA_W-1:0] w_data_seen;

   task automatic slave_clear();
      dram_if.AR_READY = 1'b0;
      dram_if.R_VALID  = 1'b0;
      dram_if.R_DATA   = '0;
      dram_if.R_RESP   = 2'b00;
      dram_if.AW_READY = 1'b0;
      dram_if.W_READY  = 1'b0;
      dram_if.B_VALID  = 1'b0;
      dram_if.B_RESP   = 2'b00;
   endtask

   task automatic pick_stall(output int n);
      n = (stall_max == 0) ? 0 : int'($urandom_range(stall_max, stall_min));
   endtask

   task automatic wait_neg(input int n, output bit ab);
      ab = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!rst_n) begin
            ab = 1'b1;
            return;
         end
      end
   endtask

   task automatic serve_read();
      logic [DEPTH_W-1:0] a;
      int n;
      int guard;
      bit ab;
      a = dram_if.AR_ADDR[DEPTH_W-1:0];
      pick_stall(n);
      wait_neg(n, ab);
      if (ab) begin slave_clear(); return; end
      dram_if.AR_READY = 1'b1;
      wait_neg(1, ab);
      dram_if.AR_READY = 1'b0;
      if (ab) begin slave_clear(); return; end
      pick_stall(n);
      wait_neg(n, ab);
      if (ab) begin slave_clear(); return; end
      dram_if.R_VALID = 1'b1;
      dram_if.R_DATA  = mem[a];
      dram_if.R_RESP  = force_resp;
      guard = 0;
      while (!dram_if.R_READY && guard < 200) begin
         wait_neg(1, ab);
         if (ab) begin slave_clear(); return; end
         guard++;
      end
      wait_neg(1, ab);
      slave_clear();
   endtask

   task automatic serve_write();
      logic [DEPTH_W-1:0] a;
      int n;
      int guard;
      bit ab;
      a = dram_if.AW_ADDR[DEPTH_W-1:0];
      aw_addr_seen = dram_if.AW_ADDR;
      pick_stall(n);
      wait_neg(n, ab);
      if (ab) begin slave_clear(); return; end
      dram_if.AW_READY = 1'b1;
      wait_neg(1, ab);
      dram_if.AW_READY = 1'b0;
      if (ab) begin slave_clear(); return; end
      guard = 0;
      while (!dram_if.W_VALID && guard < 200) begin
         wait_neg(1, ab);
         if (ab) begin slave_clear(); return; end
         guard++;
      end
      pick_stall(n);
      wait_neg(n, ab);
      if (ab) begin slave_clear(); return; end
      dram_if.W_READY = 1'b1;
      w_data_seen = dram_if.W_DATA;
      mem[a] = dram_if.W_DATA;
      wait_neg(1, ab);
      dram_if.W_READY = 1'b0;
      if (ab) begin slave_clear(); return; end
      pick_stall(n);
      wait_neg(n, ab);
      if (ab) begin slave_clear(); return; end
      dram_if.B_VALID = 1'b1;
      dram_if.B_RESP  = force_resp;
      guard = 0;
      while (!dram_if.B_READY && guard < 200) begin
         wait_neg(1, ab);
         if (ab) begin slave_clear(); return; end
         guard++;
      end
      wait_neg(1, ab);
      slave_clear();
   endtask

   initial begin
      slave_clear();
      forever begin
         @(negedge clk);
         if (!rst_n) slave_clear();
         else if (dram_if.AR_VALID) serve_read();
         else if (dram_if.AW_VALID) serve_write();
      end
   end

   // ---------------- protocol monitor ----------------
   int proto_err = 0;
   int ov_count  = 0;
   int ar_count  = 0;
   logic p_ar_v, p_ar_r, p_aw_v, p_aw_r, p_w_v, p_w_r, p_r_v, p_r_rd, p_b_v, p_b_rd, p_ov;
   logic [ADDR_W-1:0] p_ar_a, p_aw_a;
   logic [DATA_W-1:0] p_w_d;

   initial begin
      {p_ar_v, p_ar_r, p_aw_v, p_aw_r, p_w_v, p_w_r, p_r_v, p_r_rd, p_b_v, p_b_rd, p_ov} = '0;
      p_ar_a = '0; p_aw_a = '0; p_w_d = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            {p_ar_v, p_ar_r, p_aw_v, p_aw_r, p_w_v, p_w_r, p_r_v, p_r_rd, p_b_v, p_b_rd, p_ov} = '0;
            continue;
         end
         if (!dram_if.AR_VALID && dram_if.AR_ADDR != '0) proto_err++;
         if (!dram_if.AW_VALID && dram_if.AW_ADDR != '0) proto_err++;
         if (!dram_if.W_VALID && dram_if.W_DATA != '0) proto_err++;
         if (dram_if.R_READY && dram_if.AR_VALID) proto_err++;
         if (dram_if.W_VALID && dram_if.AW_VALID) proto_err++;
         if (p_ar_v && !p_ar_r && (!dram_if.AR_VALID || dram_if.AR_ADDR != p_ar_a)) proto_err++;
         if (p_aw_v && !p_aw_r && (!dram_if.AW_VALID || dram_if.AW_ADDR != p_aw_a)) proto_err++;
         if (p_w_v && !p_w_r && (!dram_if.W_VALID || dram_if.W_DATA != p_w_d)) proto_err++;
         if (p_r_rd && !p_r_v && !dram_if.R_READY) proto_err++;
         if (p_b_rd && !p_b_v && !dram_if.B_READY) proto_err++;
         if (!out_valid && (data_out != '0 || resp_err)) proto_err++;
         if (out_valid && p_ov) proto_err++;
         if (out_valid) ov_count++;
         if (dram_if.AR_VALID && !p_ar_v) ar_count++;
         p_ar_v = dram_if.AR_VALID;  p_ar_r = dram_if.AR_READY;  p_ar_a = dram_if.AR_ADDR;
         p_aw_v = dram_if.AW_VALID;  p_aw_r = dram_if.AW_READY;  p_aw_a = dram_if.AW_ADDR;
         p_w_v  = dram_if.W_VALID;   p_w_r  = dram_if.W_READY;   p_w_d  = dram_if.W_DATA;
         p_r_v  = dram_if.R_VALID;   p_r_rd = dram_if.R_READY;
         p_b_v  = dram_if.B_VALID;   p_b_rd = dram_if.B_READY;
         p_ov   = out_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_cmd(input logic dir, input logic [DEPTH_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] exp_data, input logic exp_err,
                          input string tag, output int lat);
      logic [DATA_W-1:0] got_d;
      logic [DATA_W-1:0] e;
      logic got_e;
      bit seen;
      exp_q.push_back(exp_data);
      @(negedge clk);
      in_valid = 1'b1; direction = dir; addr_dram = a; data_in = d;
      lat = 0; seen = 1'b0; got_d = '0; got_e = 1'b0;
      while (!seen && lat < BUDGET) begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
         if (out_valid) begin
            seen = 1'b1; got_d = data_out; got_e = resp_err;
         end
      end
      e = exp_q.pop_front();
      check({tag, "_done"}, 64'(seen), 64'd1);
      check({tag, "_data"}, got_d, e);
      check({tag, "_err"}, 64'(got_e), 64'(exp_err));
   endtask

   task automatic wait_sig_neg(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if ((which == 0 && dram_if.W_VALID) || (which == 1 && dram_if.R_READY) ||
             (which == 2 && out_valid)) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      int start_ov;
      int start_ar;
      bit ok;
      for (int i = 0; i < 8192; i++) mem[i] = 64'hCAFE_0000_0000_0000 | 64'(i);
      rst_n = 1'b0; in_valid = 1'b0; direction = 1'b0; addr_dram = '0; data_in = '0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_data_out", data_out, 64'd0);
      check("rst_state", 64'(state_o), 64'(S_IDLE));
      check("rst_bus", 64'(|{dram_if.AR_VALID, dram_if.AR_ADDR, dram_if.R_READY, dram_if.AW_VALID,
                             dram_if.AW_ADDR, dram_if.W_VALID, dram_if.W_DATA, dram_if.B_READY, resp_err}), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Write to the top word with fixed stalls so payloads are held several cycles.
      stall_min = 3; stall_max = 3;
      run_cmd(1'b1, 13'h1FFF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, "wr_top", lat);
      check("wr_top_awaddr", 64'(aw_addr_seen), 64'h0000_1FFF);
      check("wr_top_wdata", w_data_seen, 64'h0123_4567_89AB_CDEF);
      check("wr_top_mem", mem[8191], 64'h0123_4567_89AB_CDEF);
      run_cmd(1'b0, 13'h1FFF, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, "rd_top", lat);

      // Zero-stall latencies: out_valid seen 3 (read) / 4 (write) cycles after the command cycle.
      stall_min = 0; stall_max = 0;
      run_cmd(1'b1, 13'h0002, 64'h55AA_33CC_0F0F_F0F0, 64'd0, 1'b0, "wr_fast", lat);
      check("wr_fast_lat", 64'(lat), 64'd4);
      run_cmd(1'b0, 13'h0002, 64'd0, 64'h55AA_33CC_0F0F_F0F0, 1'b0, "rd_fast", lat);
      check("rd_fast_lat", 64'(lat), 64'd3);

      // Random 2..49 cycle stalls on every channel.
      stall_min = 2; stall_max = 49;
      run_cmd(1'b0, 13'h0000, 64'd0, 64'hCAFE_0000_0000_0000, 1'b0, "rd_stall", lat);
      check("rd_stall_proto", 64'(proto_err), 64'd0);

      // Error responses on both read and write paths.
      stall_min = 0; stall_max = 0; force_resp = 2'b10;
      run_cmd(1'b0, 13'h0001, 64'd0, 64'hCAFE_0000_0000_0001, 1'b1, "rd_slverr", lat);
      run_cmd(1'b1, 13'h0004, 64'h0000_0000_0000_0044, 64'd0, 1'b1, "wr_slverr", lat);
      force_resp = 2'b00;

      // A second command during W must be ignored.
      stall_min = 6; stall_max = 6;
      @(posedge clk); #1;
      start_ov = ov_count; start_ar = ar_count;
      @(negedge clk);
      in_valid = 1'b1; direction = 1'b1; addr_dram = 13'h0003; data_in = 64'h1111_2222_3333_4444;
      @(negedge clk);
      in_valid = 1'b0;
      wait_sig_neg(0, ok);
      check("ign_wvalid_seen", 64'(ok), 64'd1);
      check("ign_state_w", 64'(state_o), 64'(S_W));
      in_valid = 1'b1; direction = 1'b0; addr_dram = 13'h0005;
      @(negedge clk);
      in_valid = 1'b0;
      wait_sig_neg(2, ok);
      check("ign_done", 64'(ok), 64'd1);
      repeat (30) @(negedge clk);
      @(posedge clk); #1;
      check("ign_pulses", 64'(ov_count - start_ov), 64'd1);
      check("ign_no_ar", 64'(ar_count - start_ar), 64'd0);
      check("ign_mem", mem[3], 64'h1111_2222_3333_4444);

      // Reset in the middle of R clears every output at once and aborts the read.
      stall_min = 8; stall_max = 8;
      @(posedge clk); #1;
      start_ov = ov_count;
      @(negedge clk);
      in_valid = 1'b1; direction = 1'b0; addr_dram = 13'h0007;
      @(negedge clk);
      in_valid = 1'b0;
      wait_sig_neg(1, ok);
      check("rst_mid_rready_seen", 64'(ok), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_bus", 64'(|{dram_if.AR_VALID, dram_if.AR_ADDR, dram_if.R_READY, dram_if.AW_VALID,
                                 dram_if.AW_ADDR, dram_if.W_VALID, dram_if.W_DATA, dram_if.B_READY,
                                 out_valid, data_out, resp_err}), 64'd0);
      check("rst_mid_state", 64'(state_o), 64'(S_IDLE));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      @(posedge clk); #1;
      check("rst_mid_no_pulse", 64'(ov_count - start_ov), 64'd0);
      stall_min = 0; stall_max = 0;
      run_cmd(1'b0, 13'h0005, 64'd0, 64'hCAFE_0000_0000_0005, 1'b0, "rd_after_rst", lat);

      repeat (3) @(negedge clk);
      check("proto_final", 64'(proto_err), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
      $fatal(1, "watchdog expired");
   end

endmodule
